sim_link_responder: RTL and testbench
=====================================

# sim_link_responder

Far-end partner of the car's UART link: deserialises the 8N1 command byte the car transmits, validates and decodes it into motion and beacon events, and periodically serialises a 4-bit detector status byte back to the car. It sits on the simulator side of the link, where it drives the world model with the car's commands and returns obstacle detection results.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- BAUD, 9600, line rate; bit period BIT_CYC = CLK_HZ/BAUD (integer, ≥ 4)
- STATUS_PERIOD, 100_000, cycles between status-byte transmit starts
- LINK_TIMEOUT, 10_000_000, cycles without a valid frame before the link is declared dead

Ports:
- sys_clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rxd  in  1  serial input from the car's tx; idles high
- txd  out  1  serial output to the car's rx; idles high
- detector  in  4  {back, right, left, front}, sampled when each status byte starts
- moving_state  out  4  moving_state field of the last valid command
- place_beacon_pulse  out  1  one-cycle pulse on a 0→1 transition of bit 4 between valid frames
- destroy_beacon_pulse  out  1  one-cycle pulse on a 0→1 transition of bit 5 between valid frames
- frame_err  out  1  one-cycle pulse on a stop-bit or header error
- err_cnt  out  8  saturating count of frame_err pulses
- link_alive  out  1  high while a valid frame has arrived within LINK_TIMEOUT

## Operation
- Reset values: txd=1, moving_state=0, both pulses=0, frame_err=0, err_cnt=0, link_alive=0, internal previous-flag registers=0.
- rxd passes through a 2-flop synchroniser; all receive decisions use the synchronised value.
- Receive FSM states:
  - RX_IDLE: a falling edge moves to RX_START.
  - RX_START: at BIT_CYC/2, if the line is high it is a glitch and the FSM returns to RX_IDLE; otherwise it moves to RX_DATA.
  - RX_DATA: 8 samples spaced BIT_CYC apart, LSB first.
  - RX_STOP: one sample. A low stop bit gives frame_err and the byte is discarded. The FSM always returns to RX_IDLE.
- Frame format, byte[7:0]: [7:6]=2'b10 header, [5]=destroy flag, [4]=place flag, [3:0]=moving_state.
- A header other than 2'b10 gives frame_err and the byte is discarded; no other output changes.
- A valid frame:
  - loads moving_state;
  - produces place_beacon_pulse when the place flag is 1 and the previous valid frame's place flag was 0 (same rule for destroy);
  - updates the previous-flag registers;
  - reloads the timeout counter;
  - sets link_alive=1.
- Timeout counter: when it reaches LINK_TIMEOUT with no valid frame, link_alive goes to 0. The previous-flag registers clear to 0, so the first flagged frame after recovery pulses.
- err_cnt increments on each frame_err and saturates at 255.
- Transmit:
  - A free-running counter triggers a status byte every STATUS_PERIOD cycles.
  - At trigger, {4'b0000, detector} is latched. The frame is sent as start, 8 data bits LSB first, stop, each bit BIT_CYC cycles.
  - A trigger that arrives while a transmission is in progress is dropped, not queued.
- Receive and transmit are fully independent. Simultaneous rx completion and tx trigger are both serviced in the same cycle.

## Timing
- moving_state, pulses, frame_err and link_alive update on the clock edge after the mid-stop-bit sample.
- rxd-to-decision latency is 2 cycles (synchroniser) plus sampling offsets.
- The first status start bit appears STATUS_PERIOD cycles after reset release. txd goes low in the cycle after the trigger.
- The tx frame length is exactly 10×BIT_CYC cycles.
- Asserting rst mid-frame aborts both FSMs immediately: txd goes high and any partial rx byte is lost. After release, the receiver waits for the next falling edge; a partially observed frame can produce frame_err.

## Configuration
- SIM_LINK_FAILSAFE_EN defined: on link timeout, moving_state is also forced to 4'b0000 (vehicle halted) until the next valid frame.
- SIM_LINK_FAILSAFE_EN undefined: moving_state holds its last value through timeout; only link_alive drops.

## Test plan
All scenarios use CLK_HZ=1600, BAUD=100 (BIT_CYC=16), STATUS_PERIOD=400, LINK_TIMEOUT=2000.
- Send 0x85 -> moving_state=4'b0101, link_alive=1, no pulses, frame_err=0.
- Send 0x91 then 0x91 -> exactly one place_beacon_pulse, after the first frame. Then send 0xA1 -> one destroy_beacon_pulse and no place pulse.
- Send 0x45 (bad header), then 0x85 with the stop bit held low -> two frame_err pulses, err_cnt=2, moving_state unchanged.
- Drive a 5-cycle low glitch on rxd -> no frame_err and the receiver returns to idle; a following 0x83 decodes to moving_state=3.
- Set detector=4'b1010 and wait for a trigger -> txd carries 0x0A LSB-first over 160 cycles, and the next start follows 400 cycles after the previous one.
- Send 0x86, then stay silent for 2000 cycles -> link_alive=0. With SIM_LINK_FAILSAFE_EN, moving_state=0; without it, moving_state=6. Asserting rst mid-tx forces txd=1 in the same cycle.

Source files
------------

// File: rtl/sim_link_responder.sv
// sim_link_responder: simulator-side partner of the car's 8N1 UART link.
// Receives command bytes (header 2'b10, destroy, place, moving_state), turns
// them into motion state and beacon pulses, tracks link liveness, and
// periodically transmits a {4'b0000, detector} status byte back to the car.
// Optional feature macro: SIM_LINK_FAILSAFE_EN -- when defined, a link
// timeout also forces moving_state to 4'b0000 until the next valid frame.
module sim_link_responder #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int BAUD          = 9600,
    parameter int STATUS_PERIOD = 100_000,
    parameter int LINK_TIMEOUT  = 10_000_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       txd,
    input  logic [3:0] detector,
    output logic [3:0] moving_state,
    output logic       place_beacon_pulse,
    output logic       destroy_beacon_pulse,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic       link_alive
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CNT_W   = $clog2(BIT_CYC + 1);
    localparam int PER_W   = $clog2(STATUS_PERIOD + 1);
    localparam int TO_W    = $clog2(LINK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(STATUS_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LINK_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(LINK_TIMEOUT);

`ifdef SIM_LINK_FAILSAFE_EN
    localparam bit FAILSAFE = 1'b1;
`else
    localparam bit FAILSAFE = 1'b0;
`endif

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;

    // Command byte is accepted only with the 2'b10 header.
    function automatic logic header_ok(input logic [7:0] b);
        return (b[7:6] == 2'b10);
    endfunction

    // ---------------- receive path ----------------
    logic             sync1_r, sync2_r, rx_prev_r;
    logic             fall_s;
    rx_state_t        rx_state_r, rx_next_s;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_bit_r;
    logic [7:0]       rx_shift_r;
    logic             rx_cnt_clr_s, rx_shift_en_s, rx_done_s;
    logic             valid_s, err_s, expire_s;

    logic [3:0]       moving_r;
    logic             place_pulse_r, destroy_pulse_r, frame_err_r, link_alive_r;
    logic             prev_place_r, prev_destroy_r;
    logic [7:0]       err_cnt_r;
    logic [TO_W-1:0]  to_cnt_r;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= rxd;
            sync2_r   <= sync1_r;
            rx_prev_r <= sync2_r;
        end
    end

    assign fall_s = rx_prev_r & ~sync2_r;

    // Receive FSM state register.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            rx_state_r <= RX_IDLE;
        end else begin
            rx_state_r <= rx_next_s;
        end
    end

    // Receive FSM next-state and sampling strobes.
    always_comb begin
        rx_next_s     = rx_state_r;
        rx_cnt_clr_s  = 1'b0;
        rx_shift_en_s = 1'b0;
        rx_done_s     = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (fall_s) begin
                    rx_next_s    = RX_START;
                    rx_cnt_clr_s = 1'b1;
                end else begin
                    rx_next_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_clr_s = 1'b1;
                    if (sync2_r) begin
                        rx_next_s = RX_IDLE;
                    end else begin
                        rx_next_s = RX_DATA;
                    end
                end else begin
                    rx_next_s = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_clr_s  = 1'b1;
                    rx_shift_en_s = 1'b1;
                    if (rx_bit_r == 3'd7) begin
                        rx_next_s = RX_STOP;
                    end else begin
                        rx_next_s = RX_DATA;
                    end
                end else begin
                    rx_next_s = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_done_s = 1'b1;
                    rx_next_s = RX_IDLE;
                end else begin
                    rx_next_s = RX_STOP;
                end
            end
            default: begin
                rx_next_s = RX_IDLE;
            end
        endcase
    end

    // Receive bit timer, bit index and LSB-first shift register.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_cnt_r <= rx_cnt_clr_s ? '0 : rx_cnt_r + CNT_W'(1);
            if (rx_state_r != RX_DATA) begin
                rx_bit_r <= 3'd0;
            end else if (rx_shift_en_s) begin
                rx_bit_r <= rx_bit_r + 3'd1;
            end
            if (rx_shift_en_s) begin
                rx_shift_r <= {sync2_r, rx_shift_r[7:1]};
            end
        end
    end

    // Frame verdict at the mid-stop sample; timeout when the counter runs out.
    always_comb begin
        valid_s  = rx_done_s & sync2_r & header_ok(rx_shift_r);
        err_s    = rx_done_s & ~(sync2_r & header_ok(rx_shift_r));
        expire_s = ~valid_s & (to_cnt_r == TO_LAST);
    end

    // Decoded outputs, beacon edge detection, error count and link watchdog.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            moving_r        <= 4'h0;
            place_pulse_r   <= 1'b0;
            destroy_pulse_r <= 1'b0;
            frame_err_r     <= 1'b0;
            err_cnt_r       <= 8'h00;
            link_alive_r    <= 1'b0;
            prev_place_r    <= 1'b0;
            prev_destroy_r  <= 1'b0;
            to_cnt_r        <= '0;
        end else begin
            place_pulse_r   <= valid_s & rx_shift_r[4] & ~prev_place_r;
            destroy_pulse_r <= valid_s & rx_shift_r[5] & ~prev_destroy_r;
            frame_err_r     <= err_s;
            if (err_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
            if (valid_s) begin
                moving_r       <= rx_shift_r[3:0];
                prev_place_r   <= rx_shift_r[4];
                prev_destroy_r <= rx_shift_r[5];
                link_alive_r   <= 1'b1;
                to_cnt_r       <= '0;
            end else begin
                if (to_cnt_r != TO_MAX) begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                end
                if (expire_s) begin
                    // Recovery starts clean so the first flagged frame pulses.
                    prev_place_r   <= 1'b0;
                    prev_destroy_r <= 1'b0;
                    link_alive_r   <= 1'b0;
                    if (FAILSAFE) begin
                        moving_r <= 4'h0;
                    end
                end
            end
        end
    end

    // ---------------- transmit path ----------------
    logic [PER_W-1:0] per_cnt_r;
    logic             trig_s;
    tx_state_t        tx_state_r, tx_next_s;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [3:0]       tx_bit_r;
    logic [9:0]       tx_frame_r;
    logic             txd_r;
    logic             tx_start_s, tx_step_s, tx_end_s;

    // Free-running status period counter.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            per_cnt_r <= '0;
        end else if (per_cnt_r == PER_LAST) begin
            per_cnt_r <= '0;
        end else begin
            per_cnt_r <= per_cnt_r + PER_W'(1);
        end
    end

    assign trig_s = (per_cnt_r == PER_LAST);

    // Transmit FSM state register.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            tx_state_r <= TX_IDLE;
        end else begin
            tx_state_r <= tx_next_s;
        end
    end

    // Transmit FSM next-state; triggers during a frame are simply ignored.
    always_comb begin
        tx_next_s  = tx_state_r;
        tx_start_s = 1'b0;
        tx_step_s  = 1'b0;
        tx_end_s   = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (trig_s) begin
                    tx_start_s = 1'b1;
                    tx_next_s  = TX_SEND;
                end else begin
                    tx_next_s = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (tx_cnt_r == BIT_LAST) begin
                    if (tx_bit_r == 4'd9) begin
                        tx_end_s  = 1'b1;
                        tx_next_s = TX_IDLE;
                    end else begin
                        tx_step_s = 1'b1;
                    end
                end else begin
                    tx_next_s = TX_SEND;
                end
            end
            default: begin
                tx_next_s = TX_IDLE;
            end
        endcase
    end

    // Transmit shifter: frame is {stop, data[7:0], start}, shifted out LSB first.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            tx_cnt_r   <= '0;
            tx_bit_r   <= 4'd0;
            tx_frame_r <= 10'h3FF;
            txd_r      <= 1'b1;
        end else if (tx_start_s) begin
            tx_frame_r <= {1'b1, 4'b0000, detector, 1'b0};
            txd_r      <= 1'b0;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 4'd0;
        end else if (tx_step_s) begin
            tx_frame_r <= {1'b1, tx_frame_r[9:1]};
            txd_r      <= tx_frame_r[1];
            tx_cnt_r   <= '0;
            tx_bit_r   <= tx_bit_r + 4'd1;
        end else if (tx_end_s) begin
            txd_r    <= 1'b1;
            tx_cnt_r <= '0;
        end else if (tx_state_r == TX_SEND) begin
            tx_cnt_r <= tx_cnt_r + CNT_W'(1);
        end
    end

    assign txd                  = txd_r;
    assign moving_state         = moving_r;
    assign place_beacon_pulse   = place_pulse_r;
    assign destroy_beacon_pulse = destroy_pulse_r;
    assign frame_err            = frame_err_r;
    assign err_cnt              = err_cnt_r;
    assign link_alive           = link_alive_r;

endmodule

// File: tb/tb_sim_link_responder.sv
// Self-checking bench for sim_link_responder (BIT_CYC=16, STATUS_PERIOD=400,
// LINK_TIMEOUT=2000): directed scenarios plus randomized command frames,
// checked against a frame-level reference model.
module tb_sim_link_responder;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b0;
    logic       rxd     = 1'b1;
    logic       txd;
    logic [3:0] detector = 4'b0000;
    logic [3:0] moving_state;
    logic       place_beacon_pulse, destroy_beacon_pulse, frame_err, link_alive;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    // pulse monitors (count high cycles, so stretched pulses overcount)
    int mon_place = 0, mon_destroy = 0, mon_err = 0;

    // reference model state
    logic [3:0] m_moving = 4'h0;
    logic       m_prev_place = 1'b0, m_prev_destroy = 1'b0, m_link = 1'b0;
    int         m_place_n = 0, m_destroy_n = 0, m_err_n = 0;

    sim_link_responder #(
        .CLK_HZ(1600), .BAUD(100), .STATUS_PERIOD(400), .LINK_TIMEOUT(2000)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .rxd(rxd), .txd(txd), .detector(detector),
        .moving_state(moving_state), .place_beacon_pulse(place_beacon_pulse),
        .destroy_beacon_pulse(destroy_beacon_pulse), .frame_err(frame_err),
        .err_cnt(err_cnt), .link_alive(link_alive)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (place_beacon_pulse === 1'b1) mon_place++;
        if (destroy_beacon_pulse === 1'b1) mon_destroy++;
        if (frame_err === 1'b1) mon_err++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Serialise one 8N1 byte onto rxd, then idle high for a few cycles.
    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int gap);
        @(negedge sys_clk);
        rxd = 1'b0;
        repeat (16) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge sys_clk);
        end
        rxd = stop_val;
        repeat (16) @(negedge sys_clk);
        rxd = 1'b1;
        repeat (4 + gap) @(negedge sys_clk);
    endtask

    // Reference model: what one frame should do according to the frame rules.
    task automatic model_frame(input logic [7:0] b, input logic stop_val);
        if (stop_val && (b[7:6] == 2'b10)) begin
            m_moving = b[3:0];
            if (b[4] && !m_prev_place) m_place_n++;
            if (b[5] && !m_prev_destroy) m_destroy_n++;
            m_prev_place   = b[4];
            m_prev_destroy = b[5];
            m_link         = 1'b1;
        end else begin
            m_err_n++;
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ":moving"}, moving_state, m_moving);
        check_val({tag, ":place"}, mon_place, m_place_n);
        check_val({tag, ":destroy"}, mon_destroy, m_destroy_n);
        check_val({tag, ":ferr"}, mon_err, m_err_n);
        check_val({tag, ":errcnt"}, err_cnt, (m_err_n > 255) ? 255 : m_err_n);
        check_val({tag, ":link"}, link_alive, m_link);
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] b, input logic stop_val);
        send_byte(b, stop_val, 0);
        model_frame(b, stop_val);
        check_state(tag);
    endtask

    // Called at the negedge just after txd dropped for a start bit.
    task automatic check_tx_frame(input logic [7:0] exp);
        logic [8:0] bits;
        repeat (8) @(negedge sys_clk);
        bits[0] = txd;
        for (int i = 1; i < 9; i++) begin
            repeat (16) @(negedge sys_clk);
            bits[i] = txd;
        end
        check_val("tx_start_bit", bits[0], 1'b0);
        check_val("tx_data", bits[8:1], exp);
        repeat (7) @(negedge sys_clk);
        check_val("tx_bit7_hold", txd, 1'b0);
        @(negedge sys_clk);
        check_val("tx_stop_edge", txd, 1'b1);
        repeat (8) @(negedge sys_clk);
        check_val("tx_stop_mid", txd, 1'b1);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop_v;
        logic [3:0] det2;
        int         consec_err;
        int         waited;

        // ---- reset values ----
        detector = 4'b1010;
        repeat (3) @(negedge sys_clk);
        check_val("rst_txd", txd, 1'b1);
        check_val("rst_moving", moving_state, 4'h0);
        check_val("rst_place", place_beacon_pulse, 1'b0);
        check_val("rst_destroy", destroy_beacon_pulse, 1'b0);
        check_val("rst_ferr", frame_err, 1'b0);
        check_val("rst_errcnt", err_cnt, 8'h00);
        check_val("rst_link", link_alive, 1'b0);
        rst = 1'b1;

        // ---- status transmit: first start 400 cycles after release ----
        repeat (399) @(negedge sys_clk);
        check_val("tx_pre_first", txd, 1'b1);
        @(negedge sys_clk);
        check_val("tx_first_start", txd, 1'b0);
        check_tx_frame(8'h0A);
        det2     = 4'($urandom_range(0, 15));
        detector = det2;
        repeat (247) @(negedge sys_clk);
        check_val("tx_pre_second", txd, 1'b1);
        @(negedge sys_clk);
        check_val("tx_period", txd, 1'b0);
        check_tx_frame({4'b0000, det2});

        // ---- directed receive scenarios ----
        send_and_check("f85", 8'h85, 1'b1);
        send_and_check("f91a", 8'h91, 1'b1);
        send_and_check("f91b", 8'h91, 1'b1);
        send_and_check("fA1", 8'hA1, 1'b1);
        send_and_check("f45_badhdr", 8'h45, 1'b1);
        send_and_check("f85_badstop", 8'h85, 1'b0);

        // 5-cycle glitch must not be taken as a frame
        @(negedge sys_clk);
        rxd = 1'b0;
        repeat (5) @(negedge sys_clk);
        rxd = 1'b1;
        repeat (30) @(negedge sys_clk);
        check_state("glitch");
        send_and_check("f83", 8'h83, 1'b1);

        // ---- randomized frames ----
        consec_err = 0;
        for (int n = 0; n < 30; n++) begin
            b      = 8'($urandom_range(0, 255));
            stop_v = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) != 0) b[7:6] = 2'b10;
            if (consec_err >= 2) begin
                b[7:6] = 2'b10;
                stop_v = 1'b1;
            end
            send_byte(b, stop_v, $urandom_range(0, 40));
            model_frame(b, stop_v);
            if (stop_v && (b[7:6] == 2'b10)) consec_err = 0;
            else consec_err++;
            check_state("rand");
        end

        // ---- link timeout ----
        send_and_check("f96", 8'h96, 1'b1);
        repeat (1980) @(negedge sys_clk);
        check_val("to_still_alive", link_alive, 1'b1);
        repeat (20) @(negedge sys_clk);
        check_val("to_dead", link_alive, 1'b0);
        m_link         = 1'b0;
        m_prev_place   = 1'b0;
        m_prev_destroy = 1'b0;
`ifdef SIM_LINK_FAILSAFE_EN
        m_moving = 4'h0;
`endif
        check_val("to_moving", moving_state, m_moving);
        send_and_check("f96_recover", 8'h96, 1'b1);

        // ---- reset during a transmission ----
        waited = 0;
        while (txd !== 1'b0 && waited < 500) begin
            @(negedge sys_clk);
            waited++;
        end
        check_val("tx_seen_busy", (waited < 500), 1'b1);
        repeat (20) @(negedge sys_clk);
        #2 rst = 1'b0;
        #1;
        check_val("rst_mid_txd", txd, 1'b1);
        check_val("rst_mid_moving", moving_state, 4'h0);
        check_val("rst_mid_link", link_alive, 1'b0);
        check_val("rst_mid_errcnt", err_cnt, 8'h00);
        @(negedge sys_clk);
        rst = 1'b1;
        repeat (5) @(negedge sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
